// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer
// Sequences the duty cycle of an LED PWM generator from two raw push-buttons.
// MANUAL mode steps the duty up/down with saturation on each update tick;
// BREATHE mode ramps the duty between 0 and full scale on its own. Pressing
// both buttons together toggles between the two modes. The duty seen by the
// PWM comparator is only reloaded when the PWM counter wraps, so a period is
// never cut short or stretched by a duty change.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   key[1:0]     raw buttons, active-low; key[0]=UP, key[1]=DOWN
//   led          registered PWM output
//   duty         target duty, applied at the next PWM wrap
//   mode         0=MANUAL, 1=BREATHE
//   period_start one-cycle pulse when the PWM counter wraps and duty reloads
module pwm_duty_sequencer #(
  parameter int DUTY_W     = 10,
  parameter int PWM_DIV    = 16,
  parameter int TICK_DIV   = 32768,
  parameter int DEB_CYCLES = 1000,
  parameter int STEP       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        key,
  output logic              led,
  output logic [DUTY_W-1:0] duty,
  output logic              mode,
  output logic              period_start
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DUTY_W:0]   MAX_X  = (DUTY_W+1)'((1 << DUTY_W) - 1);
  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] MAX_D  = MAX_X[DUTY_W-1:0];

  typedef enum logic {
    MANUAL  = 1'b0,
    BREATHE = 1'b1
  } mode_t;

  mode_t             state, state_next;
  logic              dir_up, dir_up_next;
  logic [DUTY_W-1:0] duty_next;

  logic [1:0]        key_s1, key_s2, key_deb;
  logic [DEB_W-1:0]  deb_cnt [2];
  logic              up_p, dn_p, both, both_d, toggle;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic [PRE_W-1:0]  pre_cnt;
  logic              pre_tc, wrap;
  logic [DUTY_W-1:0] pwm_cnt, active_duty;

  logic [DUTY_W:0]   duty_x, duty_up, duty_dn;

  // Two-flop synchroniser for the raw keys. Resets to the released level so
  // the debouncer does not see a phantom press right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // Debouncer: a key's accepted level only flips once the synchronised level
  // has disagreed with it for DEB_CYCLES cycles in a row. Any agreeing sample
  // throws the partial run away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_deb    <= 2'b11;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] != key_deb[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            key_deb[i] <= key_s2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign up_p   = ~key_deb[0];
  assign dn_p   = ~key_deb[1];
  assign both   = up_p & dn_p;
  assign toggle = both & ~both_d;

  // Free-running update tick, one cycle wide at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Mode / duty state register. both_d remembers the chord so that only its
  // rising edge toggles the mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MANUAL;
      dir_up <= 1'b1;
      duty   <= '0;
      both_d <= 1'b0;
    end else begin
      state  <= state_next;
      dir_up <= dir_up_next;
      duty   <= duty_next;
      both_d <= both;
    end
  end

  assign duty_x  = {1'b0, duty};
  assign duty_up = duty_x + STEP_X;
  assign duty_dn = duty_x - STEP_X;

  // Next mode/duty. A chord edge wins over a coincident tick, and no duty
  // change happens while the chord is held. The one-bit-wider sums make the
  // saturation compares immune to wrap-around.
  always_comb begin
    state_next  = state;
    dir_up_next = dir_up;
    duty_next   = duty;
    if (toggle) begin
      case (state)
        MANUAL: begin
          state_next  = BREATHE;
          dir_up_next = 1'b1;
        end
        default: state_next = MANUAL;
      endcase
    end else if (tick && !both) begin
      case (state)
        MANUAL: begin
          if (up_p) begin
            duty_next = (duty_up > MAX_X) ? MAX_D : duty_up[DUTY_W-1:0];
          end else if (dn_p) begin
            duty_next = (duty_x < STEP_X) ? '0 : duty_dn[DUTY_W-1:0];
          end
        end
        default: begin
          if (dir_up) begin
            if (duty_up >= MAX_X) begin
              duty_next   = MAX_D;
              dir_up_next = 1'b0;
            end else begin
              duty_next = duty_up[DUTY_W-1:0];
            end
          end else begin
            if (duty_x <= STEP_X) begin
              duty_next   = '0;
              dir_up_next = 1'b1;
            end else begin
              duty_next = duty_dn[DUTY_W-1:0];
            end
          end
        end
      endcase
    end
  end

  assign mode = (state == BREATHE);

  assign pre_tc = (pre_cnt == PRE_W'(PWM_DIV - 1));
  assign wrap   = pre_tc && (pwm_cnt == MAX_D);

  // PWM engine. The active duty is captured from the target duty only on the
  // wrap, so the comparator value is constant for a whole period; a duty
  // update landing on the wrap cycle is picked up one period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      active_duty  <= '0;
      period_start <= 1'b0;
      led          <= 1'b0;
    end else begin
      pre_cnt <= pre_tc ? '0 : pre_cnt + PRE_W'(1);
      if (pre_tc) begin
        pwm_cnt <= pwm_cnt + DUTY_W'(1);
      end
      if (wrap) begin
        active_duty <= duty;
      end
      period_start <= wrap;
      led          <= (pwm_cnt < active_duty);
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer
// Self-checking bench for pwm_duty_sequencer with small parameters. A
// behavioural model tracks the block from the key rules, tick timing and PWM
// period arithmetic and is compared with the DUT every cycle; a table of key
// hold phases checks hand-derived duty/mode values, followed by an
// asynchronous reset check and a randomized key phase.
module tb_pwm_duty_sequencer;

  localparam int DUTY_W     = 4;
  localparam int PWM_DIV    = 1;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int STEP       = 1;
  localparam int PERIOD     = 1 << DUTY_W;
  localparam int DMAX       = PERIOD - 1;

  logic              clk;
  logic              rst;
  logic [1:0]        key;
  logic              led;
  logic [DUTY_W-1:0] duty;
  logic              mode;
  logic              period_start;

  int passCount;
  int totalCount;

  pwm_duty_sequencer #(
    .DUTY_W    (DUTY_W),
    .PWM_DIV   (PWM_DIV),
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES),
    .STEP      (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .led         (led),
    .duty        (duty),
    .mode        (mode),
    .period_start(period_start)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: edges since reset, target/active duty, mode,
  // direction, accepted key levels, raw key delay line and a sliding window
  // of the synchronised key samples.
  int         mN;
  int         mDuty;
  int         mActive;
  bit         mLed;
  bit         mPs;
  bit         mMode;
  bit         mDirUp;
  bit         mBothPrev;
  logic [1:0] mRaw1;
  logic [1:0] mRaw2;
  logic [1:0] mDeb;
  logic [1:0] synHist[$];

  typedef struct {
    logic [1:0] k;
    int         cycles;
    int         expDuty;
    bit         expMode;
  } vec_t;

  vec_t vecs[$];

  task automatic modelReset();
    mN        = 0;
    mDuty     = 0;
    mActive   = 0;
    mLed      = 1'b0;
    mPs       = 1'b0;
    mMode     = 1'b0;
    mDirUp    = 1'b1;
    mBothPrev = 1'b0;
    mRaw1     = 2'b11;
    mRaw2     = 2'b11;
    mDeb      = 2'b11;
    synHist.delete();
  endtask

  // One clock edge of the model, evaluated from values held before the edge.
  task automatic modelStep(input logic [1:0] k);
    int         m;
    bit         upP;
    bit         dnP;
    bit         bothP;
    bit         tickNow;
    bit         allDiff;
    logic [1:0] synced;
    m       = mN + 1;
    mLed    = (((mN / PWM_DIV) % PERIOD) < mActive);
    mPs     = ((m % (PERIOD * PWM_DIV)) == 0);
    if (mPs) mActive = mDuty;
    upP     = !mDeb[0];
    dnP     = !mDeb[1];
    bothP   = upP && dnP;
    tickNow = ((mN % TICK_DIV) == TICK_DIV - 1);
    if (bothP && !mBothPrev) begin
      mMode = !mMode;
      if (mMode) mDirUp = 1'b1;
    end else if (tickNow && !bothP) begin
      if (!mMode) begin
        if (upP) mDuty = (mDuty + STEP > DMAX) ? DMAX : mDuty + STEP;
        else if (dnP) mDuty = (mDuty - STEP < 0) ? 0 : mDuty - STEP;
      end else if (mDirUp) begin
        if (mDuty + STEP >= DMAX) begin
          mDuty  = DMAX;
          mDirUp = 1'b0;
        end else begin
          mDuty = mDuty + STEP;
        end
      end else begin
        if (mDuty <= STEP) begin
          mDuty  = 0;
          mDirUp = 1'b1;
        end else begin
          mDuty = mDuty - STEP;
        end
      end
    end
    mBothPrev = bothP;
    synced    = mRaw2;
    mRaw2     = mRaw1;
    mRaw1     = k;
    synHist.push_back(synced);
    if (synHist.size() > DEB_CYCLES) void'(synHist.pop_front());
    for (int i = 0; i < 2; i++) begin
      allDiff = (synHist.size() == DEB_CYCLES);
      foreach (synHist[j]) begin
        if (synHist[j][i] == mDeb[i]) allDiff = 1'b0;
      end
      if (allDiff) mDeb[i] = ~mDeb[i];
    end
    mN = m;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
               name, $time, actual, expected);
    end
  endtask

  // Drive keys at the negedge, advance one clock, then compare every output
  // against the model on the following negedge.
  task automatic applyStimulus(input logic [1:0] k);
    key = k;
    @(posedge clk);
    modelStep(k);
    @(negedge clk);
    checkOutput("model{led,duty,mode,ps}",
                {25'd0, led, duty, mode, period_start},
                {25'd0, mLed, DUTY_W'(mDuty), mMode, mPs});
  endtask

  task automatic addVec(input logic [1:0] k, input int cycles,
                        input int expDuty, input bit expMode);
    vec_t v;
    v.k       = k;
    v.cycles  = cycles;
    v.expDuty = expDuty;
    v.expMode = expMode;
    vecs.push_back(v);
  endtask

  initial begin
    int         highCount;
    logic [1:0] rk;
    int         len;
    passCount  = 0;
    totalCount = 0;

    addVec(2'b11, 200, 0,  1'b0);
    addVec(2'b10, 100, 15, 1'b0);
    addVec(2'b11, 10,  15, 1'b0);
    addVec(2'b01, 14,  12, 1'b0);
    addVec(2'b01, 60,  0,  1'b0);
    addVec(2'b11, 10,  0,  1'b0);
    for (int g = 0; g < 3; g++) begin
      addVec(2'b10, 2, 0, 1'b0);
      addVec(2'b11, 2, 0, 1'b0);
    end
    addVec(2'b00, 8,   0,  1'b1);
    addVec(2'b11, 30,  7,  1'b1);
    addVec(2'b11, 40,  13, 1'b1);
    addVec(2'b11, 60,  2,  1'b1);
    addVec(2'b00, 8,   3,  1'b0);
    addVec(2'b11, 20,  3,  1'b0);
    addVec(2'b01, 40,  0,  1'b0);
    addVec(2'b00, 8,   0,  1'b1);
    addVec(2'b11, 40,  9,  1'b1);

    rst = 1'b1;
    key = 2'b11;
    modelReset();
    @(negedge clk);
    checkOutput("reset led",          {31'd0, led},          32'd0);
    checkOutput("reset duty",         {28'd0, duty},         32'd0);
    checkOutput("reset mode",         {31'd0, mode},         32'd0);
    checkOutput("reset period_start", {31'd0, period_start}, 32'd0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      for (int c = 0; c < vecs[v].cycles; c++) applyStimulus(vecs[v].k);
      checkOutput($sformatf("vec%0d duty", v), {28'd0, duty}, vecs[v].expDuty);
      checkOutput($sformatf("vec%0d mode", v), {31'd0, mode}, {31'd0, vecs[v].expMode});
    end

    // Asynchronous reset in the middle of a BREATHE period at duty 9.
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst led",          {31'd0, led},          32'd0);
    checkOutput("async rst duty",         {28'd0, duty},         32'd0);
    checkOutput("async rst mode",         {31'd0, mode},         32'd0);
    checkOutput("async rst period_start", {31'd0, period_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Saturate at full scale and count led-high cycles over one full period
    // once the active duty has reached 15.
    for (int c = 0; c < 100; c++) applyStimulus(2'b10);
    highCount = 0;
    for (int c = 0; c < PERIOD; c++) begin
      applyStimulus(2'b10);
      if (led) highCount++;
    end
    checkOutput("led high per period at max", highCount, DMAX);

    // Randomized key holds of varying length, checked against the model.
    for (int b = 0; b < 80; b++) begin
      rk  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) applyStimulus(rk);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Controller that sequences the duty cycle of an LED PWM generator from two raw push-buttons. It has two modes. In MANUAL mode, the buttons step the duty up or down with saturation. In BREATHE mode, the duty ramps autonomously between 0 and full scale. Duty changes are applied only at PWM period boundaries, so the output never glitches mid-period. The block sits between the board keys and the LED pin and replaces free-running key-polled duty logic.

Parameters:
DUTY_W, 10, width of duty value and PWM counter; PWM period = 2^DUTY_W counts
PWM_DIV, 16, clocks per PWM counter increment (>=1)
TICK_DIV, 32768, clocks between duty-update ticks (>=2)
DEB_CYCLES, 1000, consecutive stable synchronised samples required to accept a key level (>=1)
STEP, 1, duty increment per tick (1..2^DUTY_W-1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key  input  2  raw buttons, active-low; key[0]=UP, key[1]=DOWN
led  output  1  PWM output
duty  output  DUTY_W  target duty (next value to be applied)
mode  output  1  0=MANUAL, 1=BREATHE
period_start  output  1  one-cycle pulse when PWM counter wraps to 0 and duty is reloaded

Behaviour:
- Reset (asynchronous, all state): led=0, duty=0, active duty=0, mode=0, period_start=0, ramp direction=up, all counters=0, debounced keys=released.
- Key conditioning, per key:
  - 2-FF synchroniser, then stability counter.
  - Debounced level updates on the edge where the synchronised level has differed from the debounced level for DEB_CYCLES consecutive cycles.
  - Any mismatch run shorter than this is discarded and the counter cleared.
  - Pressed = debounced level 0.
- Tick generator: counts 0..TICK_DIV-1 and asserts a 1-cycle internal tick at TICK_DIV-1. It is free-running, independent of keys.
- Mode toggle:
  - Occurs on the rising edge of (UP pressed AND DOWN pressed): mode inverts on the next clock.
  - Entering BREATHE: direction=up, duty unchanged.
  - Entering MANUAL: duty held at its current value.
  - While both keys are held, no duty change occurs in either mode.
- MANUAL mode, on a tick:
  - UP only: duty = min(duty+STEP, 2^DUTY_W-1).
  - DOWN only: duty = max(duty-STEP, 0).
  - Neither key or both keys: hold.
  - Arithmetic is carried out at DUTY_W+1 bits, so no wrap-around occurs.
- BREATHE mode, on a tick (keys ignored except for the toggle chord):
  - Direction up: if duty+STEP >= 2^DUTY_W-1, then duty = 2^DUTY_W-1 and direction = down; else duty += STEP.
  - Direction down: if duty <= STEP, then duty = 0 and direction = up; else duty -= STEP.
- PWM:
  - Prescaler counts 0..PWM_DIV-1.
  - On its terminal count, the DUTY_W-bit PWM counter increments and wraps from 2^DUTY_W-1 to 0.
  - On the wrap, active duty loads from duty and period_start pulses for that cycle.
  - led is registered: led = (PWM counter < active duty).
  - Duty 0 gives constant 0. Duty max gives high for all but 1 count per period.
- Simultaneous events:
  - A tick coinciding with a mode toggle: the toggle takes effect and the tick is ignored for that cycle.
  - A duty update coinciding with a PWM wrap: the wrap loads the pre-update duty; the new duty applies next period.
- Reset mid-operation: immediate return to reset values, with no partial period completed.

Test Plan:
(Bench parameters: DUTY_W=4, PWM_DIV=1, TICK_DIV=4, DEB_CYCLES=3, STEP=1.)
- Reset release, keys high for 200 cycles -> led=0, duty=0, mode=0 throughout, period_start every 16 cycles.
- Hold key=2'b10 (UP) for 100 cycles -> duty rises by 1 every 4 cycles, starting no earlier than 5 cycles after the press. It saturates at 15 and stays 15; led high 15 of 16 cycles per period once active duty=15.
- With duty=3, hold DOWN for 40 cycles -> duty 3,2,1,0, then holds 0 (no wrap to 15); led constant 0 after the next wrap.
- Glitch key[0] low for 2 cycles, repeated -> debounced level never changes, duty unchanged.
- Press both keys -> mode=1; duty ramps 0..15..0 in steps of 1 per tick, with direction reversing at 15 and at 0. Press both again -> mode=0 with duty frozen at the value present at the toggle.
- Assert rst for 1 cycle mid-BREATHE with duty=9 -> led, duty, mode and period_start go to 0 immediately, asynchronously.
